// File: rtl/vc_scheduler_pkg.sv
// rtl/vc_scheduler_pkg.sv - shared constants and state encoding for the VC scheduler
package vc_scheduler_pkg;

    // One-hot controller states
    typedef enum logic [2:0] {
        ST_INIT   = 3'b001,
        ST_IDLE   = 3'b010,
        ST_ACTIVE = 3'b100
    } state_t;

    // Bit of a VC head word that selects the destination FIFO (0 = D0, 1 = D1)
    localparam int DEST_BIT = 4;

    // VC0 grants allowed back-to-back while VC1 is also waiting
    localparam int MAX_CONSEC_DEFAULT = 4;

endpackage

// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - VC eligibility, VC0-priority grant with VC1 starvation guard
module vc_arbiter
    import vc_scheduler_pkg::*;
#(
    parameter int MAX_CONSEC = MAX_CONSEC_DEFAULT
) (
    input  logic clk,
    input  logic reset_L,
    input  logic enable,
    input  logic vc0_empty,
    input  logic vc1_empty,
    input  logic vc0_dest,
    input  logic vc1_dest,
    input  logic d0_almost_full,
    input  logic d1_almost_full,
    output logic grant_vc0,
    output logic grant_vc1
);

    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CONSEC);

    logic [CW-1:0] consec_cnt;
    logic          elig_vc0;
    logic          elig_vc1;

    // A VC may move a word only if it has one and its head's destination has room
    always_comb begin
        elig_vc0 = !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
        elig_vc1 = !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);
    end

    // VC0 wins ties until it has taken MAX_CONSEC grants in a row over a waiting VC1
    always_comb begin
        grant_vc0 = 1'b0;
        grant_vc1 = 1'b0;
        if (enable) begin
            if (elig_vc0 && elig_vc1) begin
                if (consec_cnt == CNT_MAX) begin
                    grant_vc1 = 1'b1;
                end else begin
                    grant_vc0 = 1'b1;
                end
            end else if (elig_vc0) begin
                grant_vc0 = 1'b1;
            end else if (elig_vc1) begin
                grant_vc1 = 1'b1;
            end
        end
    end

    // Count VC0 wins that made VC1 wait; any VC1 service or VC1 not waiting restarts it
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            consec_cnt <= '0;
        end else if (!elig_vc1 || grant_vc1) begin
            consec_cnt <= '0;
        end else if (grant_vc0 && (consec_cnt != CNT_MAX)) begin
            consec_cnt <= consec_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vc_scheduler.sv
// rtl/vc_scheduler.sv - moves words from two VC FIFOs into two destination FIFOs
module vc_scheduler
    import vc_scheduler_pkg::*;
#(
    parameter int DATA_SIZE  = 10,
    parameter int MAX_CONSEC = MAX_CONSEC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [DATA_SIZE-1:0] afVC_i,
    input  logic [DATA_SIZE-1:0] aeVC_i,
    input  logic [DATA_SIZE-1:0] afD_i,
    input  logic [DATA_SIZE-1:0] aeD_i,
    output logic [DATA_SIZE-1:0] afVC_o,
    output logic [DATA_SIZE-1:0] aeVC_o,
    output logic [DATA_SIZE-1:0] afD_o,
    output logic [DATA_SIZE-1:0] aeD_o,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [7:0]           vc0_data,
    input  logic [7:0]           vc1_data,
    input  logic                 d0_almost_full,
    input  logic                 d1_almost_full,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [7:0]           data_d,
    output logic                 idle
);

    state_t state;
    state_t state_next;
    logic   grant_vc0;
    logic   grant_vc1;

    vc_arbiter #(
        .MAX_CONSEC(MAX_CONSEC)
    ) u_arbiter (
        .clk           (clk),
        .reset_L       (reset_L),
        .enable        (state == ST_ACTIVE),
        .vc0_empty     (vc0_empty),
        .vc1_empty     (vc1_empty),
        .vc0_dest      (vc0_data[DEST_BIT]),
        .vc1_dest      (vc1_data[DEST_BIT]),
        .d0_almost_full(d0_almost_full),
        .d1_almost_full(d1_almost_full),
        .grant_vc0     (grant_vc0),
        .grant_vc1     (grant_vc1)
    );

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: init only honoured in IDLE; ACTIVE drains until nothing is left to move
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: state_next = ST_IDLE;
            ST_IDLE: begin
                if (init) begin
                    state_next = ST_INIT;
                end else if (!vc0_empty || !vc1_empty) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (vc0_empty && vc1_empty && !pop_vc0 && !pop_vc1) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // FSM outputs: pops follow the arbiter directly so a word can leave every cycle
    always_comb begin
        idle    = (state == ST_IDLE);
        pop_vc0 = grant_vc0;
        pop_vc1 = grant_vc1;
    end

    // One-stage push pipeline; the routing decision is frozen at pop time
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_d0 <= 1'b0;
            push_d1 <= 1'b0;
            data_d  <= 8'h00;
        end else begin
            push_d0 <= (pop_vc0 && !vc0_data[DEST_BIT]) || (pop_vc1 && !vc1_data[DEST_BIT]);
            push_d1 <= (pop_vc0 &&  vc0_data[DEST_BIT]) || (pop_vc1 &&  vc1_data[DEST_BIT]);
            if (pop_vc0) begin
                data_d <= vc0_data;
            end else if (pop_vc1) begin
                data_d <= vc1_data;
            end
        end
    end

    // Threshold registers reload only while in INIT
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            afVC_o <= '0;
            aeVC_o <= '0;
            afD_o  <= '0;
            aeD_o  <= '0;
        end else if (state == ST_INIT) begin
            afVC_o <= afVC_i;
            aeVC_o <= aeVC_i;
            afD_o  <= afD_i;
            aeD_o  <= aeD_i;
        end
    end

endmodule

// File: tb/tb_vc_scheduler.sv
// tb/tb_vc_scheduler.sv - table-driven bench for vc_scheduler
module tb_vc_scheduler;

    localparam int DS = 10;
    localparam int NROWS = 30;

    logic          clk;
    logic          reset_L;
    logic          init;
    logic [DS-1:0] afVC_i, aeVC_i, afD_i, aeD_i;
    logic [DS-1:0] afVC_o, aeVC_o, afD_o, aeD_o;
    logic          vc0_empty, vc1_empty;
    logic [7:0]    vc0_data, vc1_data;
    logic          d0_almost_full, d1_almost_full;
    logic          pop_vc0, pop_vc1, push_d0, push_d1;
    logic [7:0]    data_d;
    logic          idle;

    int tests_run;
    int tests_failed;

    vc_scheduler #(
        .DATA_SIZE (DS),
        .MAX_CONSEC(4)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .init          (init),
        .afVC_i        (afVC_i),
        .aeVC_i        (aeVC_i),
        .afD_i         (afD_i),
        .aeD_i         (aeD_i),
        .afVC_o        (afVC_o),
        .aeVC_o        (aeVC_o),
        .afD_o         (afD_o),
        .aeD_o         (aeD_o),
        .vc0_empty     (vc0_empty),
        .vc1_empty     (vc1_empty),
        .vc0_data      (vc0_data),
        .vc1_data      (vc1_data),
        .d0_almost_full(d0_almost_full),
        .d1_almost_full(d1_almost_full),
        .pop_vc0       (pop_vc0),
        .pop_vc1       (pop_vc1),
        .push_d0       (push_d0),
        .push_d1       (push_d1),
        .data_d        (data_d),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          init, e0, e1;
        logic [7:0]    d0, d1;
        logic          af0, af1;
        logic [DS-1:0] afi;
        logic          p0, p1, q0, q1;
        logic [7:0]    dd;
        logic          idl;
        logic [DS-1:0] afo;
    } vec_t;

    vec_t tbl [NROWS];

    function automatic vec_t mk(input logic i, input logic e0, input logic e1,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic af0, input logic af1, input logic [DS-1:0] afi,
                                input logic p0, input logic p1, input logic q0, input logic q1,
                                input logic [7:0] dd, input logic idl, input logic [DS-1:0] afo);
        vec_t v;
        v.init = i;   v.e0 = e0;   v.e1 = e1;   v.d0 = d0;   v.d1 = d1;
        v.af0 = af0;  v.af1 = af1; v.afi = afi;
        v.p0 = p0;    v.p1 = p1;   v.q0 = q0;   v.q1 = q1;
        v.dd = dd;    v.idl = idl; v.afo = afo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mutual-exclusion watch on every cycle out of reset
    always @(negedge clk) begin
        if (reset_L) begin
            chk("pop_exclusive", int'(pop_vc0 & pop_vc1), 0);
            chk("push_exclusive", int'(push_d0 & push_d1), 0);
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //            init e0 e1 d0     d1     af0 af1 afi | p0 p1 q0 q1 data  idle afo
        tbl[0]  = mk(0, 1, 1, 8'h00, 8'h00, 0, 0, 7,    0, 0, 0, 0, 8'h00, 0, 0);
        tbl[1]  = mk(0, 1, 1, 8'h00, 8'h00, 0, 0, 7,    0, 0, 0, 0, 8'h00, 1, 7);
        tbl[2]  = mk(0, 0, 1, 8'h15, 8'h00, 0, 0, 7,    0, 0, 0, 0, 8'h00, 1, 7);
        tbl[3]  = mk(0, 0, 1, 8'h15, 8'h00, 0, 0, 7,    1, 0, 0, 0, 8'h00, 0, 7);
        tbl[4]  = mk(0, 0, 1, 8'h1A, 8'h00, 0, 0, 7,    1, 0, 0, 1, 8'h15, 0, 7);
        tbl[5]  = mk(0, 0, 1, 8'h1F, 8'h00, 0, 0, 7,    1, 0, 0, 1, 8'h1A, 0, 7);
        tbl[6]  = mk(0, 1, 1, 8'h1F, 8'h00, 0, 1, 7,    0, 0, 0, 1, 8'h1F, 0, 7);
        tbl[7]  = mk(0, 1, 1, 8'h00, 8'h00, 0, 0, 7,    0, 0, 0, 0, 8'h1F, 1, 7);
        tbl[8]  = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    0, 0, 0, 0, 8'h1F, 1, 7);
        tbl[9]  = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 0, 0, 8'h1F, 0, 7);
        tbl[10] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 1, 0, 8'h03, 0, 7);
        tbl[11] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 1, 0, 8'h03, 0, 7);
        tbl[12] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 1, 0, 8'h03, 0, 7);
        tbl[13] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    0, 1, 1, 0, 8'h03, 0, 7);
        tbl[14] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 0, 1, 8'h90, 0, 7);
        tbl[15] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 1, 0, 8'h03, 0, 7);
        tbl[16] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 1, 0, 8'h03, 0, 7);
        tbl[17] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 1, 0, 8'h03, 0, 7);
        tbl[18] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    0, 1, 1, 0, 8'h03, 0, 7);
        tbl[19] = mk(0, 0, 0, 8'h03, 8'h90, 1, 0, 7,    0, 1, 0, 1, 8'h90, 0, 7);
        tbl[20] = mk(0, 0, 0, 8'h03, 8'h90, 1, 0, 7,    0, 1, 0, 1, 8'h90, 0, 7);
        tbl[21] = mk(0, 0, 0, 8'h03, 8'h90, 0, 0, 7,    1, 0, 0, 1, 8'h90, 0, 7);
        tbl[22] = mk(0, 1, 1, 8'h03, 8'h90, 0, 0, 7,    0, 0, 1, 0, 8'h03, 0, 7);
        tbl[23] = mk(0, 1, 1, 8'h00, 8'h00, 0, 0, 7,    0, 0, 0, 0, 8'h03, 1, 7);
        tbl[24] = mk(0, 0, 1, 8'h03, 8'h90, 0, 0, 7,    0, 0, 0, 0, 8'h03, 1, 7);
        tbl[25] = mk(1, 0, 1, 8'h03, 8'h90, 0, 0, 7,    1, 0, 0, 0, 8'h03, 0, 7);
        tbl[26] = mk(1, 1, 1, 8'h00, 8'h00, 0, 0, 300,  0, 0, 1, 0, 8'h03, 0, 7);
        tbl[27] = mk(1, 1, 1, 8'h00, 8'h00, 0, 0, 300,  0, 0, 0, 0, 8'h03, 1, 7);
        tbl[28] = mk(0, 1, 1, 8'h00, 8'h00, 0, 0, 300,  0, 0, 0, 0, 8'h03, 0, 7);
        tbl[29] = mk(0, 1, 1, 8'h00, 8'h00, 0, 0, 300,  0, 0, 0, 0, 8'h03, 1, 300);

        reset_L = 1'b0;
        init = 1'b0;
        afVC_i = 10'd7; aeVC_i = 10'd2; afD_i = 10'd9; aeD_i = 10'd1;
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        vc0_data = 8'h00; vc1_data = 8'h00;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_idle", int'(idle), 0);
        chk("reset_push", int'({push_d0, push_d1}), 0);
        chk("reset_data", int'(data_d), 0);
        chk("reset_afVC_o", int'(afVC_o), 0);
        reset_L = 1'b1;

        for (int r = 0; r < NROWS; r++) begin
            init = tbl[r].init;
            vc0_empty = tbl[r].e0;  vc1_empty = tbl[r].e1;
            vc0_data = tbl[r].d0;   vc1_data = tbl[r].d1;
            d0_almost_full = tbl[r].af0; d1_almost_full = tbl[r].af1;
            afVC_i = tbl[r].afi;
            @(negedge clk);
            chk($sformatf("row%0d_pop_vc0", r), int'(pop_vc0), int'(tbl[r].p0));
            chk($sformatf("row%0d_pop_vc1", r), int'(pop_vc1), int'(tbl[r].p1));
            chk($sformatf("row%0d_push_d0", r), int'(push_d0), int'(tbl[r].q0));
            chk($sformatf("row%0d_push_d1", r), int'(push_d1), int'(tbl[r].q1));
            chk($sformatf("row%0d_data_d", r), int'(data_d), int'(tbl[r].dd));
            chk($sformatf("row%0d_idle", r), int'(idle), int'(tbl[r].idl));
            chk($sformatf("row%0d_afVC_o", r), int'(afVC_o), int'(tbl[r].afo));
            @(posedge clk);
            #1;
        end

        // Reset arriving right after a pop must drop the pending push
        init = 1'b0;
        vc0_empty = 1'b0; vc0_data = 8'h15;
        @(negedge clk);
        chk("rst_seq_idle_before", int'(idle), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_seq_pop", int'(pop_vc0), 1);
        @(posedge clk);
        #1;
        chk("rst_seq_push_pending", int'(push_d1), 1);
        reset_L = 1'b0;
        #1;
        chk("rst_seq_push_d1", int'(push_d1), 0);
        chk("rst_seq_push_d0", int'(push_d0), 0);
        chk("rst_seq_data", int'(data_d), 0);
        chk("rst_seq_pop0", int'(pop_vc0), 0);
        chk("rst_seq_idle", int'(idle), 0);
        chk("rst_seq_afVC_o", int'(afVC_o), 0);
        chk("rst_seq_aeD_o", int'(aeD_o), 0);
        vc0_empty = 1'b1;
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        chk("rst_seq_reload_afVC", int'(afVC_o), 300);
        chk("rst_seq_reload_aeVC", int'(aeVC_o), 2);
        chk("rst_seq_reload_afD", int'(afD_o), 9);
        chk("rst_seq_reload_aeD", int'(aeD_o), 1);
        chk("rst_seq_idle_after", int'(idle), 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_seq_no_push%0d", k), int'({push_d0, push_d1}), 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
